// File: rtl/timer_pkg.sv
// Shared widths, FSM encoding and default period length for the period timer blocks.
package timer_pkg;

    localparam int COUNT_W        = 17;
    localparam int PERIOD_W       = 48;
    localparam int CLK_PER_TT_DEF = 100_000;

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        ACQUIRE  = 2'b01,
        LOCKED   = 2'b10
    } state_t;

endpackage

// File: rtl/timer_follower_if.sv
// Sync input, period preload and local timebase outputs of the follower timer.
interface timer_follower_if;
    import timer_pkg::*;

    logic                sync_in;
    logic                period_load;
    logic [PERIOD_W-1:0] period_load_data;
    logic [COUNT_W-1:0]  counter;
    logic [PERIOD_W-1:0] period;
    logic                period_done;
    logic                locked;
    logic                err_early;
    logic                err_late;
    logic [15:0]         miss_total;

    modport master (
        output sync_in, period_load, period_load_data,
        input  counter, period, period_done, locked, err_early, err_late, miss_total
    );

    modport slave (
        input  sync_in, period_load, period_load_data,
        output counter, period, period_done, locked, err_early, err_late, miss_total
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pulse followed by a rising-edge detector.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic q1_r;
    logic q2_r;
    logic q3_r;

    // q1/q2 resolve metastability, q3 holds the previous synchronised level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_r <= 1'b0;
            q2_r <= 1'b0;
            q3_r <= 1'b0;
        end else begin
            q1_r <= async_in;
            q2_r <= q1_r;
            q3_r <= q2_r;
        end
    end

    assign rise = q2_r & ~q3_r;

endmodule

// File: rtl/timer_follower.sv
// Follower period timer: locks onto the master's per-period sync pulse, flywheels through
// missing syncs and reproduces the in-period counter, period number and period tick.
module timer_follower
    import timer_pkg::*;
#(
    parameter int CLK_PER_TT = CLK_PER_TT_DEF,
    parameter int TOL        = 4,
    parameter int SYNC_LAT   = 2,
    parameter int ACQ_COUNT  = 3,
    parameter int MAX_MISS   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_follower_if.slave tif
);

    localparam logic [COUNT_W-1:0]  CNT_LAST     = COUNT_W'(CLK_PER_TT - 1);
    localparam logic [COUNT_W-1:0]  CNT_END_LO   = COUNT_W'(CLK_PER_TT - TOL);
    localparam logic [COUNT_W-1:0]  CNT_SEEN_CLR = COUNT_W'(CLK_PER_TT - TOL - 1);
    localparam logic [COUNT_W-1:0]  CNT_TOL      = COUNT_W'(TOL);
    localparam logic [COUNT_W-1:0]  CNT_LAT      = COUNT_W'(SYNC_LAT);
    localparam logic [COUNT_W-1:0]  CNT_ZERO     = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0]  CNT_ONE      = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]          GOOD_LOCK    = 8'(ACQ_COUNT);
    localparam logic [7:0]          MISS_DROP    = 8'(MAX_MISS);

    state_t              state_r, state_s;
    logic [COUNT_W-1:0]  counter_r, counter_s;
    logic [PERIOD_W-1:0] period_r, period_s, period_base_s;
    logic                period_done_r;
    logic                locked_r;
    logic                err_early_r;
    logic                err_late_r;
    logic [15:0]         miss_total_r, miss_total_s;
    logic                seen_r, seen_s;
    logic [7:0]          good_r, good_s;
    logic [7:0]          miss_r, miss_s;

    logic rise_s;
    logic active_s;
    logic in_end_s;
    logic in_start_s;
    logic accept_s;
    logic early_s;
    logic late_s;
    logic realign_s;
    logic inc_s;
    logic drop_s;

    sync_edge u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (tif.sync_in),
        .rise     (rise_s)
    );

    // Classify the synchronised edge against the pre-update counter and the seen flag
    always_comb begin
        active_s   = (state_r != UNLOCKED);
        in_end_s   = (counter_r >= CNT_END_LO);
        in_start_s = (counter_r <= CNT_TOL);
        accept_s   = active_s && rise_s && !seen_r && (in_end_s || in_start_s);
        early_s    = active_s && rise_s && !accept_s;
        late_s     = active_s && !seen_r && !rise_s && (counter_r == CNT_TOL);
        realign_s  = accept_s || (early_s && (state_r == ACQUIRE));
        // An end-window accept stands in for the natural wrap, a realign suppresses it
        inc_s      = (accept_s && in_end_s) ||
                     (active_s && !realign_s && (counter_r == CNT_LAST));
    end

    // Lock state machine with acquisition and consecutive-miss counting
    always_comb begin
        state_s = state_r;
        good_s  = good_r;
        miss_s  = miss_r;
        drop_s  = 1'b0;
        case (state_r)
            UNLOCKED: begin
                if (rise_s) begin
                    state_s = (GOOD_LOCK <= 8'd1) ? LOCKED : ACQUIRE;
                    good_s  = 8'd1;
                end else begin
                    state_s = UNLOCKED;
                    good_s  = 8'd0;
                end
                miss_s = 8'd0;
            end
            ACQUIRE: begin
                if (late_s) begin
                    state_s = UNLOCKED;
                    good_s  = 8'd0;
                    miss_s  = 8'd0;
                    drop_s  = 1'b1;
                end else if (accept_s) begin
                    good_s  = good_r + 8'd1;
                    miss_s  = 8'd0;
                    state_s = ((good_r + 8'd1) >= GOOD_LOCK) ? LOCKED : ACQUIRE;
                end else if (early_s) begin
                    good_s  = 8'd1;
                    state_s = ACQUIRE;
                end else begin
                    state_s = ACQUIRE;
                end
            end
            LOCKED: begin
                if (late_s) begin
                    if ((miss_r + 8'd1) >= MISS_DROP) begin
                        state_s = UNLOCKED;
                        good_s  = 8'd0;
                        miss_s  = 8'd0;
                        drop_s  = 1'b1;
                    end else begin
                        state_s = LOCKED;
                        miss_s  = miss_r + 8'd1;
                    end
                end else if (accept_s) begin
                    state_s = LOCKED;
                    miss_s  = 8'd0;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s = UNLOCKED;
                good_s  = 8'd0;
                miss_s  = 8'd0;
                drop_s  = 1'b1;
            end
        endcase
    end

    // Counter, seen flag, period number and miss statistics
    always_comb begin
        counter_s = counter_r;
        seen_s    = seen_r;
        if (!active_s) begin
            counter_s = rise_s ? CNT_LAT : CNT_ZERO;
            seen_s    = rise_s;
        end else if (drop_s) begin
            counter_s = CNT_ZERO;
            seen_s    = 1'b0;
        end else if (realign_s) begin
            counter_s = CNT_LAT;
            seen_s    = 1'b1;
        end else if (counter_r == CNT_LAST) begin
            counter_s = CNT_ZERO;
            seen_s    = seen_r;
        end else begin
            counter_s = counter_r + CNT_ONE;
            seen_s    = (counter_r == CNT_SEEN_CLR) ? 1'b0 : seen_r;
        end

        if (tif.period_load) begin
            period_base_s = tif.period_load_data;
        end else begin
            period_base_s = period_r;
        end
        period_s = period_base_s + {{(PERIOD_W-1){1'b0}}, inc_s};

        if (late_s && (miss_total_r != 16'hFFFF)) begin
            miss_total_s = miss_total_r + 16'd1;
        end else begin
            miss_total_s = miss_total_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= UNLOCKED;
            counter_r     <= CNT_ZERO;
            period_r      <= {PERIOD_W{1'b0}};
            period_done_r <= 1'b0;
            locked_r      <= 1'b0;
            err_early_r   <= 1'b0;
            err_late_r    <= 1'b0;
            miss_total_r  <= 16'd0;
            seen_r        <= 1'b0;
            good_r        <= 8'd0;
            miss_r        <= 8'd0;
        end else begin
            state_r       <= state_s;
            counter_r     <= counter_s;
            period_r      <= period_s;
            period_done_r <= inc_s;
            locked_r      <= (state_s == LOCKED);
            err_early_r   <= early_s;
            err_late_r    <= late_s;
            miss_total_r  <= miss_total_s;
            seen_r        <= seen_s;
            good_r        <= good_s;
            miss_r        <= miss_s;
        end
    end

    assign tif.counter     = counter_r;
    assign tif.period      = period_r;
    assign tif.period_done = period_done_r;
    assign tif.locked      = locked_r;
    assign tif.err_early   = err_early_r;
    assign tif.err_late    = err_late_r;
    assign tif.miss_total  = miss_total_r;

endmodule
